// File: rtl/lab3_3_checker.sv
// -----------------------------------------------------------------------------
// lab3_3_checker
//   Watches the count stream of the divided-clock counter from the fast board
//   clock. The divided clock is treated as data: it is synchronized, its rising
//   edge produces a one-cycle strobe, and on each strobe the count is sampled
//   and checked against previous+1 (mod 2^WIDTH).
//
// Ports
//   clk      in   board clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clk_d    in   divided clock, sampled as data
//   q_in     in   [WIDTH-1:0] count value under test
//   q_last   out  [WIDTH-1:0] last sampled count
//   locked   out  high while LOCK_RUN consecutive increments have been seen
//   err      out  one-cycle pulse on a mismatched sample
//   stall    out  one-cycle pulse when no sample arrives for TIMEOUT cycles
//   err_cnt  out  [7:0] saturating mismatch count
// -----------------------------------------------------------------------------
module lab3_3_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_RUN = 4,
  parameter int TIMEOUT  = 2**28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_d,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] q_last,
  output logic             locked,
  output logic             err,
  output logic             stall,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] TMR_MAX    = 32'(TIMEOUT - 1);
  localparam logic [7:0]  LOCK_RUN_C = 8'(LOCK_RUN);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] q_last_q, q_last_d;
  logic [7:0]       run_cnt_q, run_cnt_d;
  logic [31:0]      tmr_q, tmr_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             strobe;
  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             expire;
  logic [7:0]       run_inc;

  assign strobe  = s2_q & ~s3_q;
  assign exp_val = q_last_q + WIDTH'(1);
  assign match   = (q_in == exp_val);
  // A strobe in the expiry cycle wins, so expiry is qualified by ~strobe.
  assign expire  = (tmr_q == TMR_MAX) & ~strobe;
  assign run_inc = run_cnt_q + 8'd1;

  // State, synchronizer and all registered outputs.
  // The synchronizer resets to 1 so that clk_d already high at reset release
  // is not mistaken for a rising edge; a real low-then-high is required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      q_last_q  <= '0;
      run_cnt_q <= 8'd0;
      tmr_q     <= 32'd0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      s1_q      <= clk_d;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      q_last_q  <= q_last_d;
      run_cnt_q <= run_cnt_d;
      tmr_q     <= tmr_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state logic of the IDLE / TRACK / LOCKED tracker.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe) state_d = ST_TRACK;
        else        state_d = ST_IDLE;
      end
      ST_TRACK: begin
        if (strobe) begin
          if (match && (run_inc == LOCK_RUN_C)) state_d = ST_LOCKED;
          else                                  state_d = ST_TRACK;
        end else if (expire) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_LOCKED: begin
        if (strobe) begin
          if (match) state_d = ST_LOCKED;
          else       state_d = ST_TRACK;
        end else if (expire) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output values for the next cycle.
  always_comb begin
    q_last_d  = q_last_q;
    run_cnt_d = run_cnt_q;
    tmr_d     = tmr_q;
    err_d     = 1'b0;
    stall_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    locked_d  = (state_d == ST_LOCKED);
    case (state_q)
      ST_IDLE: begin
        tmr_d     = 32'd0;
        run_cnt_d = 8'd0;
        if (strobe) q_last_d = q_in;
        else        q_last_d = q_last_q;
      end
      ST_TRACK, ST_LOCKED: begin
        if (strobe) begin
          q_last_d = q_in;
          tmr_d    = 32'd0;
          if (match) begin
            // Once locked the run length no longer matters; hold it.
            if (state_q == ST_TRACK) run_cnt_d = run_inc;
            else                     run_cnt_d = run_cnt_q;
          end else begin
            run_cnt_d = 8'd0;
            err_d     = 1'b1;
            if (err_cnt_q == 8'hFF) err_cnt_d = err_cnt_q;
            else                    err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (expire) begin
          stall_d   = 1'b1;
          tmr_d     = 32'd0;
          run_cnt_d = 8'd0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: begin
        tmr_d     = 32'd0;
        run_cnt_d = 8'd0;
      end
    endcase
  end

  assign q_last  = q_last_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign stall   = stall_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lab3_3_checker.sv
// -----------------------------------------------------------------------------
// tb_lab3_3_checker
//   Directed-vector bench for lab3_3_checker with TIMEOUT=64, LOCK_RUN=4.
//   Inputs change 1 ns after a rising clk edge; outputs are read there too.
//   err/stall high cycles are tallied on the falling edge.
// -----------------------------------------------------------------------------
module tb_lab3_3_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_RUN = 4;
  localparam int TIMEOUT  = 64;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_d = 1'b0;
  logic [WIDTH-1:0] q_in  = 4'd0;
  logic [WIDTH-1:0] q_last;
  logic             locked;
  logic             err;
  logic             stall;
  logic [7:0]       err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int err_hi   = 0;
  int stall_hi = 0;
  int base;

  lab3_3_checker #(
    .WIDTH    (WIDTH),
    .LOCK_RUN (LOCK_RUN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_d   (clk_d),
    .q_in    (q_in),
    .q_last  (q_last),
    .locked  (locked),
    .err     (err),
    .stall   (stall),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Tally cycles in which err / stall are high.
  always @(negedge clk) begin
    if (err)   err_hi   <= err_hi + 1;
    if (stall) stall_hi <= stall_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One divided-clock period: value presented with the rising edge.
  task automatic send(input logic [3:0] v, input int hi, input int lo);
    q_in  = v;
    clk_d = 1'b1;
    repeat (hi) tick();
    clk_d = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset values ----------------
    for (int i = 0; i < 6; i++) begin
      clk_d = ~clk_d;
      tick();
    end
    check("rst_q_last",  32'(q_last),  32'd0);
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_stall",   32'(stall),   32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Release with clk_d high: must not be taken as an edge.
    q_in  = 4'd9;
    clk_d = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("rel_no_strobe_q", 32'(q_last), 32'd0);
    clk_d = 1'b0;
    repeat (3) tick();

    // ---------------- acquire and lock ----------------
    for (int v = 0; v < 4; v++) send(4'(v), 4, 4);
    q_in  = 4'd4;
    clk_d = 1'b1;
    tick();
    tick();
    check("lock_early", 32'(locked), 32'd0);
    tick();
    check("lock_rise",  32'(locked), 32'd1);
    check("lock_q_last", 32'(q_last), 32'd4);
    tick();
    clk_d = 1'b0;
    repeat (4) tick();
    check("lock_no_err", 32'(err_hi), 32'd0);

    // Continue through the 15 -> 0 wrap.
    for (int v = 5; v < 16; v++) send(4'(v), 4, 4);
    send(4'd0, 4, 4);
    send(4'd1, 4, 4);
    check("wrap_locked", 32'(locked), 32'd1);
    check("wrap_q_last", 32'(q_last), 32'd1);
    check("wrap_no_err", 32'(err_hi), 32'd0);

    // ---------------- mismatch from LOCKED ----------------
    for (int v = 2; v < 6; v++) send(4'(v), 4, 4);
    send(4'd7, 4, 4);
    check("mm_err_pulse", 32'(err_hi),  32'd1);
    check("mm_err_cnt",   32'(err_cnt), 32'd1);
    check("mm_unlocked",  32'(locked),  32'd0);
    check("mm_q_last",    32'(q_last),  32'd7);
    for (int v = 8; v < 12; v++) send(4'(v), 4, 4);
    check("relock",        32'(locked), 32'd1);
    check("relock_no_err", 32'(err_hi), 32'd1);

    // ---------------- timeout ----------------
    // Strobe of sample 11 was processed 5 ticks before send returned.
    repeat (58) tick();
    check("to_stall_early", 32'(stall),  32'd0);
    check("to_locked_pre",  32'(locked), 32'd1);
    tick();
    check("to_stall",       32'(stall),   32'd1);
    check("to_unlocked",    32'(locked),  32'd0);
    check("to_q_last_kept", 32'(q_last),  32'd11);
    check("to_err_cnt_kept", 32'(err_cnt), 32'd1);
    tick();
    check("to_stall_1cyc",  32'(stall),    32'd0);
    repeat (100) tick();
    check("to_idle_quiet",  32'(stall_hi), 32'd1);

    // ---------------- strobe on the expiry cycle ----------------
    for (int v = 12; v < 16; v++) send(4'(v), 4, 4);
    send(4'd0, 4, 4);
    check("prio_locked", 32'(locked), 32'd1);
    repeat (56) tick();
    q_in  = 4'd1;
    clk_d = 1'b1;
    repeat (3) tick();
    check("prio_no_stall", 32'(stall),  32'd0);
    check("prio_locked2",  32'(locked), 32'd1);
    check("prio_q_last",   32'(q_last), 32'd1);
    clk_d = 1'b0;
    repeat (4) tick();
    check("prio_stall_cnt", 32'(stall_hi), 32'd1);

    // ---------------- async reset mid-run ----------------
    send(4'd2, 4, 4);
    q_in  = 4'd3;
    clk_d = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_locked",  32'(locked),  32'd0);
    check("arst_q_last",  32'(q_last),  32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    #4;
    rst_n = 1'b1;
    tick();
    clk_d = 1'b0;
    repeat (3) tick();
    for (int v = 5; v < 10; v++) send(4'(v), 4, 4);
    check("arst_relock",   32'(locked),  32'd1);
    check("arst_q_last2",  32'(q_last),  32'd9);
    check("arst_no_err",   32'(err_cnt), 32'd0);
    check("arst_err_hi",   32'(err_hi),  32'd1);

    // ---------------- saturation ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    base = err_hi;
    for (int i = 0; i < 300; i++) send(4'd3, 1, 1);
    repeat (3) tick();
    check("sat_pulses", 32'(err_hi - base), 32'd299);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 3; i++) send(4'd3, 1, 1);
    repeat (3) tick();
    check("sat_hold", 32'(err_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
